// File: rtl/etapa_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register for the MIPS datapath.
// Single-outstanding fetch, decode stall via a one-entry skid buffer, redirect with in-flight squash.
module etapa_fetch #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [31:0]        NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic [5:0]        if_id_op
);

    typedef enum logic [1:0] {START, FETCH, HOLD, DROP} fetchState_t;

    fetchState_t       stateReg, stateNext;
    logic [ADDR_W-1:0] pcReg, pcNext;
    logic              reqReg, reqNext;
    logic              ifIdValidReg, ifIdValidNext;
    logic [31:0]       ifIdInstrReg, ifIdInstrNext;
    logic [ADDR_W-1:0] ifIdPc4Reg, ifIdPc4Next;
    logic              skidValidReg, skidValidNext;
    logic [31:0]       skidInstrReg, skidInstrNext;
    logic [ADDR_W-1:0] skidPc4Reg, skidPc4Next;

    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] redirectTarget;
    logic              unusedRedirectLsbs;

    assign pcPlus4            = pcReg + ADDR_W'(4);
    assign redirectTarget     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unusedRedirectLsbs = ^redirect_pc[1:0];

    always_comb begin
        stateNext     = stateReg;
        pcNext        = pcReg;
        ifIdValidNext = ifIdValidReg;
        ifIdInstrNext = ifIdInstrReg;
        ifIdPc4Next   = ifIdPc4Reg;
        skidValidNext = skidValidReg;
        skidInstrNext = skidInstrReg;
        skidPc4Next   = skidPc4Reg;

        case (stateReg)
            START: begin
                stateNext = FETCH;
            end

            FETCH: begin
                if (redirect) begin
                    ifIdValidNext = 1'b0;
                    ifIdInstrNext = NOP_INSTR;
                    pcNext        = redirectTarget;
                    skidValidNext = 1'b0;
                    // A response arriving with the redirect is simply dropped; otherwise it is still owed.
                    stateNext     = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    pcNext = pcPlus4;
                    if (!stall) begin
                        ifIdValidNext = 1'b1;
                        ifIdInstrNext = imem_rdata;
                        ifIdPc4Next   = pcPlus4;
                    end else begin
                        skidValidNext = 1'b1;
                        skidInstrNext = imem_rdata;
                        skidPc4Next   = pcPlus4;
                        stateNext     = HOLD;
                    end
                end else if (!stall) begin
                    ifIdValidNext = 1'b0;
                    ifIdInstrNext = NOP_INSTR;
                end
            end

            HOLD: begin
                if (redirect) begin
                    ifIdValidNext = 1'b0;
                    ifIdInstrNext = NOP_INSTR;
                    pcNext        = redirectTarget;
                    skidValidNext = 1'b0;
                    stateNext     = FETCH;
                end else if (!stall) begin
                    ifIdValidNext = skidValidReg;
                    ifIdInstrNext = skidInstrReg;
                    ifIdPc4Next   = skidPc4Reg;
                    skidValidNext = 1'b0;
                    stateNext     = FETCH;
                end
            end

            DROP: begin
                if (redirect) begin
                    ifIdValidNext = 1'b0;
                    ifIdInstrNext = NOP_INSTR;
                    pcNext        = redirectTarget;
                    skidValidNext = 1'b0;
                end else if (!stall) begin
                    ifIdValidNext = 1'b0;
                    ifIdInstrNext = NOP_INSTR;
                end
                // The stale response retires the squashed fetch, even if a new redirect lands with it.
                if (imem_rvalid) begin
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = START;
            end
        endcase

        reqNext = (stateNext == FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= START;
            pcReg        <= RESET_PC;
            reqReg       <= 1'b0;
            ifIdValidReg <= 1'b0;
            ifIdInstrReg <= NOP_INSTR;
            ifIdPc4Reg   <= '0;
            skidValidReg <= 1'b0;
            skidInstrReg <= NOP_INSTR;
            skidPc4Reg   <= '0;
        end else begin
            stateReg     <= stateNext;
            pcReg        <= pcNext;
            reqReg       <= reqNext;
            ifIdValidReg <= ifIdValidNext;
            ifIdInstrReg <= ifIdInstrNext;
            ifIdPc4Reg   <= ifIdPc4Next;
            skidValidReg <= skidValidNext;
            skidInstrReg <= skidInstrNext;
            skidPc4Reg   <= skidPc4Next;
        end
    end

    assign imem_req    = reqReg;
    assign imem_addr   = pcReg;
    assign if_id_valid = ifIdValidReg;
    assign if_id_instr = ifIdInstrReg;
    assign if_id_pc4   = ifIdPc4Reg;
    assign if_id_op    = ifIdInstrReg[31:26];

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed bench for etapa_fetch: streaming, stall/skid, redirect squash, async reset, PC wrap.
module tb_etapa_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  if_id_op;

    logic        wReq;
    logic [31:0] wAddr;
    logic        wRvalid;
    logic [31:0] wRdata;
    logic        wValid;
    logic [31:0] wInstr;
    logic [31:0] wPc4;
    logic [5:0]  wOp;

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    always #5 clk = ~clk;

    etapa_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_op(if_id_op)
    );

    etapa_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(wReq), .imem_addr(wAddr),
        .imem_rvalid(wRvalid), .imem_rdata(wRdata),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .if_id_valid(wValid), .if_id_instr(wInstr),
        .if_id_pc4(wPc4), .if_id_op(wOp)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {6'b100011, a[25:0]};
    endfunction

    // Instruction memory for the main instance: latches the address, answers after lat cycles.
    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] pAddr;
        pend = 1'b0; cnt = 0; pAddr = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (!pend && imem_req) begin
                    pend = 1'b1; pAddr = imem_addr; cnt = 0;
                end
                if (pend) begin
                    cnt++;
                    if (cnt >= lat) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = memWord(pAddr);
                        pend        = 1'b0;
                    end
                end
            end
        end
    end

    // Single-cycle memory for the wrap-around instance.
    initial begin
        wRvalid = 1'b0; wRdata = '0;
        forever begin
            @(negedge clk);
            wRvalid = 1'b0;
            if (rst_n && wReq) begin
                wRvalid = 1'b1;
                wRdata  = memWord(wAddr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIfId(input string tag, input logic v, input logic [31:0] instr,
                             input logic [31:0] pc4);
        check({tag, "_valid"}, if_id_valid, v);
        check({tag, "_instr"}, if_id_instr, instr);
        check({tag, "_pc4"}, if_id_pc4, pc4);
        check({tag, "_op"}, if_id_op, instr[31:26]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", if_id_valid, 0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        @(negedge clk) rst_n = 1'b1;
        #1;
        check("start_noreq", imem_req, 0);
        tick();
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, 32'h0);
        check("fetch_valid", if_id_valid, 0);
        check("wrap_req", wReq, 1);
        check("wrap_addr", wAddr, 32'hFFFF_FFFC);

        // Back-to-back stream with a 1-cycle memory
        for (int i = 0; i < 4; i++) begin
            tick();
            checkIfId("seq", 1'b1, 32'h8C00_0000 + 32'(i * 4), 32'(i * 4 + 4));
            check("seq_addr", imem_addr, 32'(i * 4 + 4));
            check("seq_lw_op", if_id_op, 32'b100011);
            if (i == 0) begin
                check("wrap_w0_instr", wInstr, 32'h8FFF_FFFC);
                check("wrap_w0_pc4", wPc4, 32'h0);
                check("wrap_w1_addr", wAddr, 32'h0);
            end
            if (i == 1) begin
                check("wrap_w1_instr", wInstr, 32'h8C00_0000);
                check("wrap_w1_pc4", wPc4, 32'h4);
            end
        end

        // Stall for 3 cycles while the word at 0x10 returns
        stall = 1'b1;
        tick();
        checkIfId("stall0", 1'b1, 32'h8C00_000C, 32'h10);
        check("stall0_req", imem_req, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkIfId("stall_hold", 1'b1, 32'h8C00_000C, 32'h10);
            check("stall_hold_req", imem_req, 0);
        end
        stall = 1'b0;
        tick();
        checkIfId("skid_out", 1'b1, 32'h8C00_0010, 32'h14);
        check("skid_out_req", imem_req, 1);
        check("skid_out_addr", imem_addr, 32'h14);
        tick();
        checkIfId("after_skid", 1'b1, 32'h8C00_0014, 32'h18);

        // Asynchronous reset in the middle of a fetch
        lat = 3;
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_valid", if_id_valid, 0);
        check("arst_instr", if_id_instr, 32'h0);
        check("arst_pc4", if_id_pc4, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // 3-cycle memory after restart
        tick();
        check("l3_req", imem_req, 1);
        check("l3_addr", imem_addr, 32'h0);
        tick();
        tick();
        check("l3_bubble", if_id_valid, 0);
        tick();
        checkIfId("l3_w0", 1'b1, 32'h8C00_0000, 32'h4);
        repeat (3) tick();
        checkIfId("l3_w1", 1'b1, 32'h8C00_0004, 32'h8);
        check("l3_addr8", imem_addr, 32'h8);

        // Redirect while the fetch of 0x8 is in flight; low bits must be dropped
        redirect = 1'b1; redirect_pc = 32'h43;
        tick();
        check("rd_req", imem_req, 0);
        check("rd_valid", if_id_valid, 0);
        check("rd_instr", if_id_instr, 32'h0);
        check("rd_addr", imem_addr, 32'h40);
        redirect = 1'b0; redirect_pc = '0;
        tick();
        check("drop_req", imem_req, 0);
        check("drop_valid", if_id_valid, 0);
        tick();
        check("drop_exit_req", imem_req, 1);
        check("drop_exit_addr", imem_addr, 32'h40);
        check("stale_discard", if_id_valid, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rd_bubble", if_id_valid, 0);
        end
        tick();
        checkIfId("rd_target", 1'b1, 32'h8C00_0040, 32'h44);

        // Redirect together with stall while in HOLD
        lat = 1;
        stall = 1'b1;
        tick();
        checkIfId("hold_in", 1'b1, 32'h8C00_0040, 32'h44);
        check("hold_in_req", imem_req, 0);
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        checkIfId("hold_rd", 1'b0, 32'h0, 32'h44);
        check("hold_rd_req", imem_req, 1);
        check("hold_rd_addr", imem_addr, 32'h80);
        redirect = 1'b0; redirect_pc = '0;
        tick();
        check("hold2_req", imem_req, 0);
        check("hold2_valid", if_id_valid, 0);
        stall = 1'b0;
        tick();
        checkIfId("hold2_out", 1'b1, 32'h8C00_0080, 32'h84);
        check("hold2_addr", imem_addr, 32'h84);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
